// File: rtl/serial_rx_8.sv
// serial_rx_8: serial-to-parallel receiver with a one-entry valid/ready
// holding register and a sticky overrun flag.
// Optional feature macro: PARITY_EN (adds an even-parity bit per frame and
// the Parity_Err output).
module serial_rx_8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Shift_In,
  input  logic                       Shift_En,
  input  logic                       Clear,
  input  logic                       Ready,
  output logic [WIDTH-1:0]           Data_Out,
  output logic                       Valid,
  output logic                       Overrun,
`ifdef PARITY_EN
  output logic                       Parity_Err,
`endif
  output logic [$clog2(WIDTH+1)-1:0] Bit_Count
);

  localparam int CW = $clog2(WIDTH+1);

`ifdef PARITY_EN
  typedef enum logic {S_DATA, S_PARITY} state_t;
`else
  typedef enum logic {S_DATA} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, shift_nxt, frame;
  logic             last_bit, commit;
`ifdef PARITY_EN
  logic             par_bad;
`endif

  // Next shift-register value; the frame completes on the WIDTH-th strobe
  // so this is also the committed frame in the no-parity build.
  assign shift_nxt = MSB_FIRST ? {sr[WIDTH-2:0], Shift_In}
                               : {Shift_In, sr[WIDTH-1:1]};
  assign last_bit  = (Bit_Count == CW'(WIDTH-1));

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_DATA;
    else          state <= state_nxt;
  end

  // Next state and commit request; Clear outranks Shift_En
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    frame     = shift_nxt;
`ifdef PARITY_EN
    par_bad   = 1'b0;
`endif
    if (Clear) begin
      state_nxt = S_DATA;
    end else if (Shift_En) begin
      case (state)
        S_DATA: begin
          if (last_bit) begin
`ifdef PARITY_EN
            state_nxt = S_PARITY;
`else
            commit    = 1'b1;
`endif
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          // Data is already complete in sr; this strobe carries parity only.
          state_nxt = S_DATA;
          commit    = 1'b1;
          frame     = sr;
          par_bad   = ^{sr, Shift_In};
        end
`endif
        default: state_nxt = S_DATA;
      endcase
    end
  end

  // Shift register and bit counter; counter wraps at frame completion
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr        <= '0;
      Bit_Count <= '0;
    end else if (Clear) begin
      sr        <= '0;
      Bit_Count <= '0;
    end else if (Shift_En && state == S_DATA) begin
      sr        <= shift_nxt;
      Bit_Count <= last_bit ? '0 : Bit_Count + CW'(1);
    end
  end

  // Holding register: commit when empty or being drained on the same edge,
  // otherwise drop the frame and flag overrun
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data_Out   <= '0;
      Valid      <= 1'b0;
      Overrun    <= 1'b0;
`ifdef PARITY_EN
      Parity_Err <= 1'b0;
`endif
    end else begin
      if (commit) begin
        if (!Valid || Ready) begin
          Data_Out   <= frame;
          Valid      <= 1'b1;
`ifdef PARITY_EN
          Parity_Err <= par_bad;
`endif
        end else begin
          Overrun    <= 1'b1;
        end
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end
      if (Clear) Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_rx_8.sv
// Directed bench for serial_rx_8: reset, gapped reception, back-to-back
// handshake, overrun/Clear, abort, MSB-first ordering and (when built with
// PARITY_EN) parity error reporting.
module tb_serial_rx_8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Shift_In = 1'b0, Shift_En = 1'b0, Clear = 1'b0, Ready = 1'b0;
  logic [7:0] Data_Out;
  logic       Valid, Overrun;
  logic [3:0] Bit_Count;

  logic       m_in = 1'b0, m_en = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, m_ovr;
  logic [3:0] m_cnt;

`ifdef PARITY_EN
  logic       Parity_Err, m_perr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  serial_rx_8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Shift_In(Shift_In), .Shift_En(Shift_En),
    .Clear(Clear), .Ready(Ready), .Data_Out(Data_Out), .Valid(Valid),
    .Overrun(Overrun),
`ifdef PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .Bit_Count(Bit_Count));

  serial_rx_8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .Clk(Clk), .Reset_n(Reset_n), .Shift_In(m_in), .Shift_En(m_en),
    .Clear(1'b0), .Ready(1'b0), .Data_Out(m_data), .Valid(m_valid),
    .Overrun(m_ovr),
`ifdef PARITY_EN
    .Parity_Err(m_perr),
`endif
    .Bit_Count(m_cnt));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    Shift_In = b; Shift_En = 1'b1;
    tick();
    Shift_En = 1'b0;
    repeat (gap) tick();
  endtask

  // LSB-first frame; Ready optionally raised for the final (committing) strobe.
  task automatic send_frame(input logic [7:0] d, input int gap, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
`ifndef PARITY_EN
      if (i == 7 && rdy_last) Ready = 1'b1;
`endif
      send_bit(d[i], (i == 7) ? 0 : gap);
    end
`ifdef PARITY_EN
    if (rdy_last) Ready = 1'b1;
    send_bit(^d, 0);
`endif
    Ready = 1'b0;
  endtask

  task automatic drain();
    Ready = 1'b1; tick(); Ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({Valid, Overrun, Data_Out, Bit_Count} !== 14'd0) begin
      errors++; $display("FAIL reset_state got v=%b o=%b d=%h c=%0d want all 0", Valid, Overrun, Data_Out, Bit_Count);
    end
    Reset_n = 1'b1; tick();
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    checks++;
    if (Bit_Count !== 4'd3) begin
      errors++; $display("FAIL reset_pre_count got %0d want 3", Bit_Count);
    end
    #2 Reset_n = 1'b0; #1;
    checks++;
    if (Bit_Count !== 4'd0 || Valid !== 1'b0) begin
      errors++; $display("FAIL reset_async got c=%0d v=%b want 0 0", Bit_Count, Valid);
    end
    tick(); Reset_n = 1'b1; tick();
    send_frame(8'h5A, 0, 1'b0);
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'h5A || Overrun !== 1'b0) begin
      errors++; $display("FAIL reset_fresh_frame got v=%b d=%h o=%b want 1 5a 0", Valid, Data_Out, Overrun);
    end
    drain();
    checks++;
    if (Valid !== 1'b0) begin
      errors++; $display("FAIL reset_drain got v=%b want 0", Valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] d;
    d = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(d[i], 2);
    checks++;
    if (Valid !== 1'b0 || Bit_Count !== 4'd7) begin
      errors++; $display("FAIL gap_seven_bits got v=%b c=%0d want 0 7", Valid, Bit_Count);
    end
`ifdef PARITY_EN
    send_bit(d[7], 0);
    send_bit(^d, 0);
`else
    send_bit(d[7], 0);
`endif
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'hA5 || Bit_Count !== 4'd0) begin
      errors++; $display("FAIL gap_frame got v=%b d=%h c=%0d want 1 a5 0", Valid, Data_Out, Bit_Count);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (Valid !== 1'b1 || Data_Out !== 8'hA5) begin
        errors++; $display("FAIL gap_hold%0d got v=%b d=%h want 1 a5", k, Valid, Data_Out);
      end
    end
  endtask

  task automatic test_back_to_back();
    // 0xA5 still held from the previous test
    send_frame(8'h3C, 1, 1'b1);
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'h3C || Overrun !== 1'b0) begin
      errors++; $display("FAIL b2b got v=%b d=%h o=%b want 1 3c 0", Valid, Data_Out, Overrun);
    end
    drain();
    checks++;
    if (Valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got v=%b want 0", Valid);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 0, 1'b0);
    send_frame(8'h22, 0, 1'b0);
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'h11 || Overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_drop got v=%b d=%h o=%b want 1 11 1", Valid, Data_Out, Overrun);
    end
    drain();
    checks++;
    if (Valid !== 1'b0 || Overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky got v=%b o=%b want 0 1", Valid, Overrun);
    end
    Clear = 1'b1; tick(); Clear = 1'b0;
    checks++;
    if (Overrun !== 1'b0 || Valid !== 1'b0) begin
      errors++; $display("FAIL ovr_clear got o=%b v=%b want 0 0", Overrun, Valid);
    end
  endtask

  task automatic test_clear_abort();
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    Clear = 1'b1; Shift_En = 1'b1; Shift_In = 1'b1;
    tick();
    Clear = 1'b0; Shift_En = 1'b0;
    checks++;
    if (Bit_Count !== 4'd0 || Valid !== 1'b0) begin
      errors++; $display("FAIL clr_abort got c=%0d v=%b want 0 0", Bit_Count, Valid);
    end
    send_frame(8'h81, 0, 1'b0);
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'h81 || Overrun !== 1'b0) begin
      errors++; $display("FAIL clr_next_frame got v=%b d=%h o=%b want 1 81 0", Valid, Data_Out, Overrun);
    end
    drain();
  endtask

  task automatic test_msb_first();
    logic [7:0] d;
    d = 8'hB4;
    for (int i = 7; i >= 0; i--) begin
      m_in = d[i]; m_en = 1'b1; tick(); m_en = 1'b0;
    end
`ifdef PARITY_EN
    m_in = ^d; m_en = 1'b1; tick(); m_en = 1'b0;
`endif
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hB4) begin
      errors++; $display("FAIL msb_first got v=%b d=%h want 1 b4", m_valid, m_data);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'hA5;
    for (int i = 0; i < 8; i++) send_bit(d[i], 0);
    send_bit(1'b0, 0);
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'hA5 || Parity_Err !== 1'b0) begin
      errors++; $display("FAIL par_good got v=%b d=%h pe=%b want 1 a5 0", Valid, Data_Out, Parity_Err);
    end
    drain();
    for (int i = 0; i < 8; i++) send_bit(d[i], 0);
    send_bit(1'b1, 0);
    checks++;
    if (Valid !== 1'b1 || Data_Out !== 8'hA5 || Parity_Err !== 1'b1) begin
      errors++; $display("FAIL par_bad got v=%b d=%h pe=%b want 1 a5 1", Valid, Data_Out, Parity_Err);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_gapped();
    test_back_to_back();
    test_overrun();
    test_clear_abort();
    test_msb_first();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
